i2s_tx_10xe_aud_stream_arbiter: RTL
===================================

Name: i2s_tx_10xe_aud_stream_arbiter

Overview:
- Round-robin arbiter that shares the I2S transmitter's single AXI-Stream audio input (s_axis_aud_*) between NUM_SRC upstream audio sources.
- Grants are frame-atomic: once granted, a source owns the stream for exactly CH_PER_FRAME accepted samples, so left/right or multichannel groups are never interleaved.
- Output is registered (one-entry buffer) and drives the transmitter's s_axis_aud_tdata/tid/tvalid and receives its tready.

Parameters:
- NUM_SRC, 4, number of upstream sources (2..8).
- CH_PER_FRAME, 2, samples per frame per grant (1..8).
- DATA_W, 32, sample width.
- TID_W, 3, channel-id width.

Ports:
- s_axis_aud_aclk  in  1  clock for the whole block.
- s_axis_aud_aresetn  in  1  synchronous, active-low reset.
- cfg_en  in  1  arbitration enable; sampled only in IDLE.
- src_tdata  in  NUM_SRC*DATA_W  per-source sample; source i occupies bits [i*DATA_W +: DATA_W].
- src_tid  in  NUM_SRC*TID_W  per-source channel id, packed the same way.
- src_tvalid  in  NUM_SRC  per-source valid.
- src_tready  out  NUM_SRC  per-source ready.
- m_axis_aud_tdata  out  DATA_W  to transmitter s_axis_aud_tdata.
- m_axis_aud_tid  out  TID_W  to transmitter s_axis_aud_tid.
- m_axis_aud_tvalid  out  1  to transmitter s_axis_aud_tvalid.
- m_axis_aud_tready  in  1  from transmitter s_axis_aud_tready.
- grant_id  out  $clog2(NUM_SRC)  current owner; valid while busy=1.
- busy  out  1  high in XFER.
- frame_done  out  1  one-cycle pulse on acceptance of the last sample of a frame.
- tid_seq_err  out  1  one-cycle pulse when an accepted sample's tid differs from the expected slot index.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - All outputs go to 0; src_tready is 0.
  - State returns to IDLE, slot counter to 0, and rr_last to NUM_SRC-1, so source 0 has first priority.
  - Reset mid-frame discards the partial frame and the output register contents.
- States:
  - IDLE: src_tready=0. If cfg_en=1 and any src_tvalid=1, select the first requester searching from rr_last+1 upward with wrap. On that edge: latch grant_id, set slot=0, and go to XFER. Otherwise stay in IDLE.
  - XFER:
    - src_tready[grant_id] = !m_axis_aud_tvalid || m_axis_aud_tready; all other src_tready=0.
    - Accept = src_tvalid[g] && src_tready[g].
    - On accept: load the output register with the data/tid of g, set m_axis_aud_tvalid=1, and increment slot.
    - If slot==CH_PER_FRAME-1 at accept: pulse frame_done, set rr_last=g, and go to IDLE.
- Output register:
  - m_axis_aud_tvalid clears when m_axis_aud_tready=1 and no new accept occurs in the same cycle.
  - Simultaneous drain and accept keeps tvalid=1 with the new data.
  - m_axis_aud_tdata/tid are held stable while tvalid=1 and tready=0.
- Latency and throughput:
  - 1 cycle from source accept to m_axis_aud_tvalid.
  - Full throughput within a frame.
  - One IDLE bubble cycle between frames.
- Boundary conditions:
  - cfg_en deasserted in XFER: the current frame completes; no new grant is issued.
  - Owner drops tvalid mid-frame: the grant is held indefinitely (no timeout) and the other sources stall.
  - Single requester: it is re-granted after each bubble.
  - All sources idle: remain in IDLE; outputs drain normally.
- tid_seq_err:
  - Pulses on an accept whose src_tid != slot, with slot zero-extended to TID_W.
  - The sample is still forwarded unchanged.
- Widths: slot counter is $clog2(CH_PER_FRAME+1) bits and never exceeds CH_PER_FRAME-1.

Decomposition:
- Package i2s_tx_10xe_arb_pkg holds:
  - the state enum typedef (IDLE, XFER);
  - default-width localparams;
  - a function next_rr(req, last) returning the round-robin winner index.
- One natural sub-module: i2s_tx_10xe_axis_out_reg, the one-entry AXI-Stream output register with ready pass-through.

Test Plan:
- Reset then src_tvalid=4'b1111, tids 0,1, m_tready=1 -> grant order 0,1,2,3,0; each frame is 2 beats with tid 0 then 1; frame_done pulses 4 times; one bubble between frames.
- Source 2 alone valid with data 32'hA5A5_0000/32'hA5A5_0001 -> busy=1, grant_id=2; output tdata matches 1 cycle after each accept.
- m_tready held 0 for 5 cycles mid-frame -> m_tdata/tid stable; src_tready[g]=0 after the register fills; resumes with no data loss.
- cfg_en dropped after beat 0 of a frame from source 1 -> beat 1 still transferred, frame_done pulses, then IDLE with no further grant despite src_tvalid=1111.
- Source 0 sends tids 0,2 -> tid_seq_err pulses on beat 2; data 2 is forwarded unchanged.
- aresetn=0 mid-frame with m_tvalid=1 -> next cycle all outputs 0; after release, source 0 is granted first.

Source files
------------

// File: rtl/i2s_tx_10xe_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for the
// I2S transmitter audio stream arbiter.
package i2s_tx_10xe_arb_pkg;

  localparam int unsigned DEF_NUM_SRC      = 4;
  localparam int unsigned DEF_CH_PER_FRAME = 2;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_TID_W        = 3;
  localparam int unsigned MAX_SRC          = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // First requester after 'last', wrapping over n sources.
  function automatic logic [2:0] next_rr(input logic [MAX_SRC-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    logic [2:0]  idx3;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_SRC; i++) begin
      idx  = (32'(last) + i) % n;
      idx3 = idx[2:0];
      if (i <= n && !found && req[idx3]) begin
        win   = idx3;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/i2s_tx_10xe_axis_out_reg.sv
// One-entry AXI-Stream register: loads on in_valid, drains on out_tready,
// and holds data stable while stalled.
module i2s_tx_10xe_axis_out_reg
  import i2s_tx_10xe_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TID_W  = DEF_TID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TID_W-1:0]  in_tid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [TID_W-1:0]  out_tid,
  output logic              out_tvalid,
  input  logic              out_tready
);

  // Room exists when empty or when the current entry leaves this cycle.
  assign in_ready = !out_tvalid || out_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tid    <= '0;
    end else if (in_valid && in_ready) begin
      out_tvalid <= 1'b1;
      out_tdata  <= in_data;
      out_tid    <= in_tid;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_tx_10xe_aud_stream_arbiter.sv
// Frame-atomic round-robin arbiter sharing the I2S transmitter audio input
// among NUM_SRC sources; each grant carries exactly CH_PER_FRAME samples.
module i2s_tx_10xe_aud_stream_arbiter
  import i2s_tx_10xe_arb_pkg::*;
#(
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int CH_PER_FRAME = DEF_CH_PER_FRAME,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TID_W        = DEF_TID_W
) (
  input  logic                        s_axis_aud_aclk,
  input  logic                        s_axis_aud_aresetn,
  input  logic                        cfg_en,
  input  logic [NUM_SRC*DATA_W-1:0]   src_tdata,
  input  logic [NUM_SRC*TID_W-1:0]    src_tid,
  input  logic [NUM_SRC-1:0]          src_tvalid,
  output logic [NUM_SRC-1:0]          src_tready,
  output logic [DATA_W-1:0]           m_axis_aud_tdata,
  output logic [TID_W-1:0]            m_axis_aud_tid,
  output logic                        m_axis_aud_tvalid,
  input  logic                        m_axis_aud_tready,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        tid_seq_err
);

  localparam int GID_W  = $clog2(NUM_SRC);
  localparam int SLOT_W = $clog2(CH_PER_FRAME + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CH_PER_FRAME - 1);
  localparam logic [GID_W-1:0]  LAST_SRC  = GID_W'(NUM_SRC - 1);

  arb_state_e          state;
  logic [GID_W-1:0]    rr_last;
  logic [SLOT_W-1:0]   slot;
  logic [MAX_SRC-1:0]  req_ext;
  logic [GID_W-1:0]    winner;
  logic [DATA_W-1:0]   g_data;
  logic [TID_W-1:0]    g_tid;
  logic                g_valid;
  logic                g_ready;
  logic                accept;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_SRC-1:0] = src_tvalid;
  end

  assign winner  = GID_W'(next_rr(req_ext, 3'(rr_last), NUM_SRC));
  assign g_data  = src_tdata[int'(grant_id)*DATA_W +: DATA_W];
  assign g_tid   = src_tid[int'(grant_id)*TID_W +: TID_W];
  assign g_valid = src_tvalid[grant_id];
  assign busy    = (state == ST_XFER);

  // Valid/ready: a beat moves only on a cycle where valid and ready are both
  // high; valid never waits on ready, and only the owner ever sees ready.
  always_comb begin
    src_tready = '0;
    if (state == ST_XFER && s_axis_aud_aresetn)
      src_tready[grant_id] = g_ready;
  end

  assign accept = (state == ST_XFER) && g_valid && g_ready && s_axis_aud_aresetn;

  always_ff @(posedge s_axis_aud_aclk) begin
    if (!s_axis_aud_aresetn) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      slot        <= '0;
      rr_last     <= LAST_SRC;
      frame_done  <= 1'b0;
      tid_seq_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      tid_seq_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_en && |src_tvalid) begin
            grant_id <= winner;
            slot     <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            tid_seq_err <= (g_tid != TID_W'(slot));
            if (slot == LAST_SLOT) begin
              slot       <= '0;
              frame_done <= 1'b1;
              rr_last    <= grant_id;
              state      <= ST_IDLE;
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  i2s_tx_10xe_axis_out_reg #(
    .DATA_W (DATA_W),
    .TID_W  (TID_W)
  ) u_out_reg (
    .clk        (s_axis_aud_aclk),
    .rst_n      (s_axis_aud_aresetn),
    .in_valid   (accept),
    .in_data    (g_data),
    .in_tid     (g_tid),
    .in_ready   (g_ready),
    .out_tdata  (m_axis_aud_tdata),
    .out_tid    (m_axis_aud_tid),
    .out_tvalid (m_axis_aud_tvalid),
    .out_tready (m_axis_aud_tready)
  );

endmodule
